// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the sequential 16x16 multiplier
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEP_W = 2;
  localparam int SH0    = 0;
  localparam int SH8    = 8;
  localparam int SH16   = 16;
  localparam int PROD_W = 32;
  localparam int OP_W   = 16;
  localparam int HALF_W = 8;

endpackage

// File: rtl/mul.sv
// rtl/mul.sv - combinational 8x8 unsigned multiplier
module mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);

  assign prod = {8'd0, a} * {8'd0, b};

endmodule

// File: rtl/mul16_seq_ctrl.sv
// rtl/mul16_seq_ctrl.sv - 16x16 multiplier built from four 8x8 steps on one multiplier
module mul16_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [HALF_W-1:0]   mul_a, mul_b;
  logic [2*HALF_W-1:0] pp;
  logic [4:0]          sh;
  logic [PROD_W-1:0]   pp_shifted;

  mul u_mul (
    .a    (mul_a),
    .b    (mul_b),
    .prod (pp)
  );

  // State, operand, accumulator and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand half select and partial-product alignment for the current step
  always_comb begin
    mul_a = step_q[1] ? a_q[15:8] : a_q[7:0];
    mul_b = step_q[0] ? b_q[15:8] : b_q[7:0];
    case (step_q)
      2'd0:    sh = 5'(SH0);
      2'd3:    sh = 5'(SH16);
      default: sh = 5'(SH8);
    endcase
    pp_shifted = {16'd0, pp} << sh;
  end

  // Next-state, accumulate and completion counting
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          acc_d  = '0;
          step_d = '0;
          if (ZERO_SKIP && ((a == '0) || (b == '0))) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + STEP_W'(1);
        if (step_q == 2'd3) begin
          state_d = DONE;
          step_d  = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == DONE);
    prod      = acc_q;
    op_count  = cnt_q;
  end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb/tb_mul16_seq_ctrl.sv - directed self-checking bench for mul16_seq_ctrl
module tb_mul16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] prod1;
  logic [15:0] op_count1;

  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] prod2;
  logic [3:0]  op_count2;

  int total = 0;
  int bad   = 0;
  logic sel = 1'b0;

  logic        ir, ov;
  logic [31:0] pr;
  assign ir = sel ? in_ready2  : in_ready1;
  assign ov = sel ? out_valid2 : out_valid1;
  assign pr = sel ? prod2      : prod1;

  always #5 clk = ~clk;

  mul16_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .prod(prod1), .busy(busy1), .op_count(op_count1)
  );

  mul16_seq_ctrl #(.ZERO_SKIP(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .prod(prod2), .busy(busy2), .op_count(op_count2)
  );

  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [31:0] ep, input int el, input string nm);
    int lat;
    total++;
    if (ir !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready before issue: got %b want 1", nm, ir);
    end
    if (sel) begin a2 = ia; b2 = ib; in_valid2 = 1'b1; out_ready2 = 1'b1; end
    else     begin a1 = ia; b1 = ib; in_valid1 = 1'b1; out_ready1 = 1'b1; end
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    a1 = 16'hDEAD; b1 = 16'hBEEF; a2 = 16'hDEAD; b2 = 16'hBEEF;
    lat = 0;
    while (ov !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != el) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
    end
    total++;
    if (pr !== ep) begin
      bad++;
      $display("FAIL %s prod: got %h want %h", nm, pr, ep);
    end
    @(posedge clk); #1;
    total++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      bad++;
      $display("FAIL %s after handshake: in_ready=%b out_valid=%b want 1/0", nm, ir, ov);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 ||
        prod1 !== 32'd0 || op_count1 !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: ir=%b ov=%b busy=%b prod=%h cnt=%h want 1 0 0 0 0",
               in_ready1, out_valid1, busy1, prod1, op_count1);
    end
    total++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || op_count2 !== 4'd0) begin
      bad++;
      $display("FAIL reset_state2: ir=%b ov=%b cnt=%h want 1 0 0", in_ready2, out_valid2, op_count2);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    do_op(16'h0003, 16'h0005, 32'h0000000F, 4, "basic_3x5");
    total++;
    if (op_count1 !== 16'd1) begin
      bad++;
      $display("FAIL basic_op_count: got %0d want 1", op_count1);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4, "max_operands");
    do_op(16'h1234, 16'h5678, 32'h06260060, 4, "b2b_1234x5678");
    total++;
    if (op_count1 !== 16'd3) begin
      bad++;
      $display("FAIL b2b_op_count: got %0d want 3", op_count1);
    end
  endtask

  task automatic test_zero_skip();
    sel = 1'b0;
    do_op(16'h0000, 16'h1234, 32'd0, 0, "zskip_a0");
    do_op(16'h1234, 16'h0000, 32'd0, 0, "zskip_b0");
    sel = 1'b1;
    do_op(16'h0000, 16'h1234, 32'd0, 4, "nozskip_a0");
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    int lat;
    sel = 1'b0;
    cnt0 = op_count1;
    out_ready1 = 1'b0;
    a1 = 16'h00FF; b1 = 16'h0100; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int k = 0; k < 3; k++) begin
      a1 = 16'h1111; b1 = 16'h2222; in_valid1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid1 !== 1'b1 || prod1 !== 32'h0000FF00 || in_ready1 !== 1'b0 || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: ov=%b prod=%h ir=%b busy=%b want 1 0000ff00 0 1",
                 k, out_valid1, prod1, in_ready1, busy1);
      end
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || op_count1 !== cnt0 + 16'd1) begin
      bad++;
      $display("FAIL bp_release: ov=%b ir=%b cnt=%0d want 0 1 %0d",
               out_valid1, in_ready1, op_count1, cnt0 + 16'd1);
    end
    do_op(16'h0002, 16'h0007, 32'h0000000E, 4, "bp_followup");
  endtask

  task automatic test_reset_mid_calc();
    sel = 1'b0;
    out_ready1 = 1'b1;
    a1 = 16'h1234; b1 = 16'h5678; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || op_count1 !== 16'd0) begin
      bad++;
      $display("FAIL rst_async: ir=%b ov=%b cnt=%0d want 1 0 0", in_ready1, out_valid1, op_count1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid1 !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_pulse%0d: got %b want 0", k, out_valid1);
      end
    end
    do_op(16'h0102, 16'h0304, 32'h00030A08, 4, "after_rst");
  endtask

  task automatic test_saturation();
    logic [31:0] ep;
    sel = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ep = 32'(i + 1) * 32'd3;
      do_op(16'(i + 1), 16'h0003, ep, 4, "sat_op");
      if (i == 14) begin
        total++;
        if (op_count2 !== 4'hF) begin
          bad++;
          $display("FAIL sat_reach: got %h want f", op_count2);
        end
      end
    end
    total++;
    if (op_count2 !== 4'hF) begin
      bad++;
      $display("FAIL sat_hold: got %h want f", op_count2);
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_skip();
    test_backpressure();
    test_reset_mid_calc();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul16_seq_ctrl.md
Name: mul16_seq_ctrl

Overview:
Sequential 16x16 unsigned multiplier controller. It time-shares one combinational 8x8 multiplier over four partial-product steps and accumulates the result into a 32-bit product. It has valid/ready handshakes on input and output, and sits between an operand-issuing master and a result consumer. Each operation costs one 8x8 multiplier instance instead of four.

Parameters:
ZERO_SKIP, 1, when 1 an operand pair with a==0 or b==0 bypasses CALC and completes with prod=0 in one cycle.
CNT_W, 16, width of the saturating completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  16  multiplicand, sampled on input handshake only
b  input  16  multiplier, sampled on input handshake only
out_valid  output  1  prod valid (high only in DONE)
out_ready  input  1  consumer accepts prod
prod  output  32  unsigned product a*b
busy  output  1  high in CALC or DONE
op_count  output  CNT_W  completed output handshakes, saturating at all-ones

Behaviour:
- Reset is asynchronous, active-high (rst):
  - state=IDLE, step=0, acc=0, a_r=b_r=0, op_count=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, busy=0, prod=0.
- FSM states are IDLE, CALC and DONE. in_ready, out_valid and busy decode directly from state, with no extra register stage.
- IDLE:
  - On in_valid&in_ready: latch a_r<=a, b_r<=b, acc<=0, step<=0.
  - If ZERO_SKIP and (a==0 or b==0), go to DONE. Otherwise go to CALC.
  - a and b are ignored when no handshake occurs.
- CALC: one step per cycle, with step counting 0..3.
  - step0: pp = a_r[7:0]*b_r[7:0], added with shift 0.
  - step1: pp = a_r[7:0]*b_r[15:8], added with shift 8.
  - step2: pp = a_r[15:8]*b_r[7:0], added with shift 8.
  - step3: pp = a_r[15:8]*b_r[15:8], added with shift 16.
  - Each step does acc <= acc + (zero-extend(pp) << shift), 32-bit modulo. No overflow is possible because the final value is at most 0xFFFE0001.
  - After the step3 update, go to DONE with step back to 0.
- DONE:
  - prod = acc, held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE and increment op_count, saturating.
  - No new operand is accepted in the same cycle as the output handshake.
- Latency, with the input handshake at the rising edge ending cycle T:
  - CALC occupies cycles T+1..T+4, and out_valid first rises in cycle T+5.
  - On the zero-skip path, out_valid rises in cycle T+1.
  - Minimum throughput is one operation per 6 cycles (2 on the zero-skip path).
- prod outside DONE equals acc, but its value there is not meaningful; the bench checks prod only while out_valid=1.
- in_valid high while busy: the operands are not accepted, and the master must hold them until in_ready.
- out_ready high outside DONE has no effect.
- rst mid-CALC or mid-DONE: the operation is aborted, no out_valid pulse is issued, and op_count is cleared.
- Operand changes on a/b after the handshake have no effect on the result.
- The 8x8 sub-multiplier is purely combinational. Its inputs are muxed by step, and its output is consumed in the same cycle.

Decomposition:
- Package mul_seq_pkg:
  - state enum {IDLE, CALC, DONE}.
  - step width constant (2).
  - shift constants SH0=0, SH8=8, SH16=16.
  - PROD_W=32, OP_W=16, HALF_W=8.
- One sub-module: the existing combinational 8x8 unsigned multiplier mul (a[7:0], b[7:0], prod[15:0]), instantiated once.
- The operand mux, accumulator and FSM stay in mul16_seq_ctrl.

Test Plan:
1. Reset, then a=0x0003, b=0x0005 with out_ready=1 -> out_valid in cycle T+5, prod=0x0000000F, then in_ready=1 the next cycle and op_count=1.
2. a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001. Then a=0x1234, b=0x5678 back-to-back -> prod=0x06260060, each at T+5.
3. ZERO_SKIP=1: a=0x0000, b=0x1234 -> out_valid at T+1 with prod=0. ZERO_SKIP=0 with the same operands -> out_valid at T+5 with prod=0.
4. Backpressure: a=0x00FF, b=0x0100, out_ready low for 3 cycles in DONE -> prod=0x0000FF00 stable, in_ready=0, in_valid with new operands ignored. Then out_ready=1 -> IDLE.
5. Assert rst asynchronously mid-CALC (step=2) -> out_valid stays 0, in_ready=1 immediately, op_count=0. Then a=0x0102, b=0x0304 -> prod=0x00030A08.
6. Drive op_count to saturation (force CNT_W=4, 16+ operations) -> op_count holds 0xF.
